cfg_stream_loader: RTL
======================

CFG_STREAM_LOADER -- requirements
Module: cfg_stream_loader

Interface
REQ-001 SHALL have parameter MAGIC, default 8'hC5, header tag value required in header bits [31:24].
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_valid  input  1  host word valid.
REQ-005 SHALL have port s_data  input  32  host word.
REQ-006 SHALL have port s_last  input  1  last word of host packet.
REQ-007 SHALL have port s_ready  output  1  loader accepts word; a transfer occurs when s_valid and s_ready are both high.
REQ-008 SHALL have port o_cfg_sel_module  output  2  target module: 00 ibf network, 01 ibf mux, 10 bv, 11 bf.
REQ-009 SHALL have port o_cfg_sram_sel  output  8  SRAM select.
REQ-010 SHALL have port o_cfg_addr_write  output  7  SRAM write address.
REQ-011 SHALL have port o_cfg_wr_en  output  1  single-cycle write strike to the config manager.
REQ-012 SHALL have port o_cfg_data  output  64  write data.
REQ-013 SHALL have port o_err_cnt  output  8  rejected-command count, saturating at 255.
REQ-014 SHALL have port o_wr_cnt  output  16  issued-write count, wrapping modulo 2^16.

Function
REQ-015 SHALL treat each command as 3 words: header, data_lo (data[31:0]), data_hi (data[63:32]).
REQ-016 SHALL decode the header as: [31:24] tag, [23:22] sel_module, [21:14] sram_sel, [13:7] addr, [6:0] reserved.
REQ-017 SHALL implement states HDR, LO, HI, ISSUE, DROP; reset state HDR.
REQ-018 SHALL drive s_ready high in HDR, LO, HI, DROP and low in ISSUE.
REQ-019 SHALL validate the header on transfer in HDR; it is valid only if tag==MAGIC and reserved==0.
REQ-020 SHALL apply per-module range checks: sel 00 requires sram_sel any and addr<4; sel 01 requires sram_sel<16 and addr<4; sel 10 requires sram_sel<32 and addr<64; sel 11 requires sram_sel<64 and addr any.
REQ-021 SHALL, in HDR: on a valid header without s_last, latch the fields and go to LO.
REQ-022 SHALL, in HDR: on a valid header with s_last, increment o_err_cnt and stay in HDR.
REQ-023 SHALL, in HDR: on an invalid header, increment o_err_cnt; go to DROP if s_last is low, else stay in HDR.
REQ-024 SHALL, in LO: on transfer, latch data_lo; if s_last is high, increment o_err_cnt (truncation) and return to HDR with no write; otherwise go to HI.
REQ-025 SHALL, in HI: on transfer, latch data_hi and go to ISSUE; s_last on this word is legal and ends the packet.
REQ-026 SHALL, in ISSUE, spend exactly one cycle with o_cfg_wr_en=1, all latched fields on outputs, o_wr_cnt incremented, then go to HDR.
REQ-027 SHALL, in DROP, discard words until a transfer with s_last, then go to HDR; no counters change in DROP.
REQ-028 SHALL register all outputs: o_cfg_wr_en rises in the cycle immediately after the data_hi transfer edge.
REQ-029 SHALL drive o_cfg_sel_module, o_cfg_sram_sel, o_cfg_addr_write and o_cfg_data to zero in every cycle where o_cfg_wr_en=0.
REQ-030 SHALL give a maximum throughput of one write per 4 cycles; back-to-back commands within one packet are legal.
REQ-031 SHALL hold state with no side effects while s_valid is low in any state (stall).
REQ-032 SHALL ignore s_data and s_last whenever no transfer occurs.
REQ-033 SHALL hold o_err_cnt at 255 once saturated; o_wr_cnt SHALL wrap 65535 -> 0.

Reset
REQ-034 SHALL, while rst is high, force state HDR, all outputs 0 (s_ready included), o_err_cnt=0, o_wr_cnt=0 and latched fields 0, independent of clk.
REQ-035 SHALL discard any partial command on reset assertion mid-command; no write is issued for it after release.
REQ-036 SHALL raise s_ready on the first clk edge after rst deasserts.

Verification
REQ-037 SHALL cover: header 0xC5_C0_00_00 (sel 11, sram 0, addr 0), lo 0x89ABCDEF, hi 0x01234567 last -> one-cycle wr_en, sel=3, data=0x0123456789ABCDEF, wr_cnt=1.
REQ-038 SHALL cover: header with tag 0xC4 followed by 2 words, last on the 2nd -> err_cnt=1, no wr_en, next valid command accepted normally.
REQ-039 SHALL cover: sel 01, addr=5 -> err_cnt=1, remaining words dropped until last; sel 01, addr=3, sram=15 -> write issued.
REQ-040 SHALL cover: s_last on data_lo -> err_cnt=1, state HDR, no wr_en.
REQ-041 SHALL cover: two commands back-to-back with s_valid held high -> wr_en pulses 4 cycles apart, s_ready low exactly in those pulse cycles.
REQ-042 SHALL cover: rst asserted asynchronously between data_lo and data_hi -> outputs 0 immediately, no write after release, and the next full command writes correctly.

Source files
------------

// File: rtl/cfg_stream_loader.sv
// Configuration stream loader: parses 3-word host commands (header, data_lo, data_hi)
// and issues single-cycle validated write strikes to the config manager.
module cfg_stream_loader #(
  parameter logic [7:0] MAGIC = 8'hC5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [1:0]  o_cfg_sel_module,
  output logic [7:0]  o_cfg_sram_sel,
  output logic [6:0]  o_cfg_addr_write,
  output logic        o_cfg_wr_en,
  output logic [63:0] o_cfg_data,
  output logic [7:0]  o_err_cnt,
  output logic [15:0] o_wr_cnt
);

  typedef enum logic [2:0] {ST_HDR, ST_LO, ST_HI, ST_ISSUE, ST_DROP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  sram_q, sram_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] lo_q, lo_d;
  logic        ready_q, ready_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  sel_out_q, sel_out_d;
  logic [7:0]  sram_out_q, sram_out_d;
  logic [6:0]  addr_out_q, addr_out_d;
  logic [63:0] data_out_q, data_out_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] wcnt_q, wcnt_d;

  logic        xfer, hdr_ok, range_ok, err_inc, issue;
  logic [1:0]  h_sel;
  logic [7:0]  h_sram;
  logic [6:0]  h_addr;

  // Handshake: a word moves only when s_valid and s_ready are both high at a rising
  // edge; s_valid may be held across stalls, and s_data/s_last are ignored otherwise.
  assign xfer   = s_valid & ready_q;
  assign h_sel  = s_data[23:22];
  assign h_sram = s_data[21:14];
  assign h_addr = s_data[13:7];

  always_comb begin
    range_ok = 1'b0;
    case (h_sel)
      2'd0:    range_ok = (h_addr < 7'd4);
      2'd1:    range_ok = (h_sram < 8'd16) && (h_addr < 7'd4);
      2'd2:    range_ok = (h_sram < 8'd32) && (h_addr < 7'd64);
      default: range_ok = (h_sram < 8'd64);
    endcase
  end

  assign hdr_ok = (s_data[31:24] == MAGIC) && (s_data[6:0] == 7'd0) && range_ok;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sram_d  = sram_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    err_inc = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (xfer) begin
          if (hdr_ok && !s_last) begin
            sel_d   = h_sel;
            sram_d  = h_sram;
            addr_d  = h_addr;
            state_d = ST_LO;
          end else begin
            err_inc = 1'b1;
            state_d = (!hdr_ok && !s_last) ? ST_DROP : ST_HDR;
          end
        end
      end
      ST_LO: begin
        if (xfer) begin
          lo_d = s_data;
          if (s_last) begin
            err_inc = 1'b1;
            state_d = ST_HDR;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (xfer) begin
          issue   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_HDR;
      ST_DROP: begin
        if (xfer && s_last) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  // The data_hi word goes straight into the output register, so the strike appears
  // in the cycle right after its transfer edge and lasts exactly one cycle.
  always_comb begin
    ready_d    = (state_d != ST_ISSUE);
    wr_en_d    = issue;
    sel_out_d  = issue ? sel_q : 2'd0;
    sram_out_d = issue ? sram_q : 8'd0;
    addr_out_d = issue ? addr_q : 7'd0;
    data_out_d = issue ? {s_data, lo_q} : 64'd0;
    err_d      = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    wcnt_d     = issue ? wcnt_q + 16'd1 : wcnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HDR;
      sel_q      <= 2'd0;
      sram_q     <= 8'd0;
      addr_q     <= 7'd0;
      lo_q       <= 32'd0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      sel_out_q  <= 2'd0;
      sram_out_q <= 8'd0;
      addr_out_q <= 7'd0;
      data_out_q <= 64'd0;
      err_q      <= 8'd0;
      wcnt_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sram_q     <= sram_d;
      addr_q     <= addr_d;
      lo_q       <= lo_d;
      ready_q    <= ready_d;
      wr_en_q    <= wr_en_d;
      sel_out_q  <= sel_out_d;
      sram_out_q <= sram_out_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign s_ready          = ready_q;
  assign o_cfg_wr_en      = wr_en_q;
  assign o_cfg_sel_module = sel_out_q;
  assign o_cfg_sram_sel   = sram_out_q;
  assign o_cfg_addr_write = addr_out_q;
  assign o_cfg_data       = data_out_q;
  assign o_err_cnt        = err_q;
  assign o_wr_cnt         = wcnt_q;

endmodule
